// File: rtl/aes_mode_engine.sv
// ECB/CTR (and optionally CBC) mode sequencer around one iterative AES encrypt core.
// Define AES_MODE_CBC_EN to build the CBC chaining path; otherwise mode 01 is rejected like 11.
module aes_mode_engine #(
    parameter int BLOCK_W = 128,
    parameter int KEY_W   = 256,
    parameter int CTR_W   = 32,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [LEN_W-1:0]   num_blocks,
    input  logic [BLOCK_W-1:0] iv,
    input  logic [KEY_W-1:0]   key,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_data_in,
    output logic [KEY_W-1:0]   core_key,
    input  logic [BLOCK_W-1:0] core_data_out,
    input  logic               core_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);
    typedef enum logic [2:0] {IDLE, WAIT_IN, CORE, HOLD_OUT, FINISH} state_t;

    state_t             state, state_nx;
    logic [1:0]         mode_q;
    logic [LEN_W-1:0]   remaining;
    logic [BLOCK_W-1:0] chain;   // CBC chaining value, or CTR counter block
    logic [BLOCK_W-1:0] p_q;
    logic               mode_ok;

    always_comb begin
        mode_ok = (mode == 2'b00) || (mode == 2'b10);
`ifdef AES_MODE_CBC_EN
        mode_ok = mode_ok || (mode == 2'b01);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:     if (start && mode_ok)
                          state_nx = (num_blocks == '0) ? FINISH : WAIT_IN;
            WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = CORE;
            end
            CORE:     if (core_valid) state_nx = HOLD_OUT;
            HOLD_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = (remaining > LEN_W'(1)) ? WAIT_IN : FINISH;
            end
            FINISH:   state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // done/err are registered so they land in IDLE: busy has already dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= '0;
            remaining    <= '0;
            chain        <= '0;
            p_q          <= '0;
            out_data     <= '0;
            core_start   <= 1'b0;
            core_data_in <= '0;
            core_key     <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            core_start <= 1'b0;
            done       <= (state == FINISH);
            err        <= (state == IDLE) && start && !mode_ok;
            case (state)
                IDLE: if (start && mode_ok) begin
                    mode_q    <= mode;
                    remaining <= num_blocks;
                    chain     <= iv;
                    core_key  <= key;
                end
                WAIT_IN: if (in_valid) begin
                    p_q        <= in_data;
                    core_start <= 1'b1;
                    case (mode_q)
`ifdef AES_MODE_CBC_EN
                        2'b01:   core_data_in <= in_data ^ chain;
`endif
                        2'b10:   core_data_in <= chain;
                        default: core_data_in <= in_data;
                    endcase
                end
                CORE: if (core_valid) begin
                    case (mode_q)
`ifdef AES_MODE_CBC_EN
                        2'b01: begin
                            out_data <= core_data_out;
                            chain    <= core_data_out;
                        end
`endif
                        2'b10: begin
                            out_data           <= core_data_out ^ p_q;
                            chain[CTR_W-1:0]   <= chain[CTR_W-1:0] + CTR_W'(1);
                        end
                        default: out_data <= core_data_out;
                    endcase
                end
                HOLD_OUT: if (out_ready) remaining <= remaining - LEN_W'(1);
                default: ;
            endcase
        end
    end
endmodule
